// File: rtl/uci_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uci_line_arbiter
// Brief   : Line-atomic round-robin arbiter sharing one UCI character stream.
// Revision: 1.0
// ============================================================================
module uci_line_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [NUM_REQ*8-1:0] req_char_in,
    input  logic [NUM_REQ-1:0]   req_valid_in,
    output logic [NUM_REQ-1:0]   req_ready_out,
    output logic [7:0]           char_out,
    output logic                 char_out_valid,
    input  logic                 char_out_ready,
    output logic [NUM_REQ-1:0]   grant_out,
    output logic                 timeout_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]       C_NEWLINE = 8'h0A;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [NUM_REQ-1:0] r_grant;
    logic [7:0]         r_char;
    logic               r_valid;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_free;
    logic               w_gvalid;
    logic [7:0]         w_gchar;
    logic               w_accept;
    logic [IDX_W-1:0]   w_pick_idx;

    assign w_free   = !r_valid || char_out_ready;
    assign w_gvalid = req_valid_in[r_last];
    assign w_gchar  = req_char_in[r_last*8 +: 8];
    assign w_accept = (r_state == ST_PASS) && w_free && w_gvalid;

    // Scan in reverse so the final hit is the nearest index after r_last.
    always_comb begin
        w_pick_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid_in[(int'(r_last) + i) % NUM_REQ]) begin
                w_pick_idx = IDX_W'((int'(r_last) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        req_ready_out = '0;
        if (r_state == ST_PASS && w_free) begin
            req_ready_out[r_last] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_IDLE;
            r_last    <= C_LAST_RST;
            r_grant   <= '0;
            r_char    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (char_out_ready) begin
                        r_valid <= 1'b0;
                    end
                    if (|req_valid_in) begin
                        r_last  <= w_pick_idx;
                        r_grant <= NUM_REQ'(1) << w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_accept) begin
                        r_char  <= w_gchar;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        if (w_gchar == C_NEWLINE) begin
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        if (w_free) begin
                            r_valid <= 1'b0;
                        end
                        if (r_cnt != C_CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        // Fire on the same edge that the counter reaches the limit.
                        if (r_cnt == C_CNT_MAX - 1'b1) begin
                            r_timeout <= 1'b1;
                            r_grant   <= '0;
                            r_state   <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_free) begin
                        r_char  <= C_NEWLINE;
                        r_valid <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign char_out       = r_char;
    assign char_out_valid = r_valid;
    assign grant_out      = r_grant;
    assign timeout_out    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uci_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uci_line_arbiter
// Brief   : Directed self-checking bench for uci_line_arbiter.
// Revision: 1.0
// ============================================================================
module tb_uci_line_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [23:0] req_char_in;
    logic [2:0]  req_valid_in;
    logic [2:0]  req_ready_out;
    logic [7:0]  char_out;
    logic        char_out_valid;
    logic        char_out_ready;
    logic [2:0]  grant_out;
    logic        timeout_out;

    int total = 0;
    int bad   = 0;

    uci_line_arbiter #(
        .NUM_REQ        (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .req_char_in    (req_char_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .char_out       (char_out),
        .char_out_valid (char_out_valid),
        .char_out_ready (char_out_ready),
        .grant_out      (grant_out),
        .timeout_out    (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_char(input int idx, input logic [7:0] c);
        req_char_in[idx*8 +: 8] = c;
    endtask

    task automatic do_reset();
        rst_n_in       = 1'b0;
        req_valid_in   = '0;
        req_char_in    = '0;
        char_out_ready = 1'b1;
        tick();
        tick();
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_in       = 1'b0;
        char_out_ready = 1'b1;
        req_char_in    = '0;
        req_valid_in   = 3'b110;
        set_char(1, 8'h41);
        set_char(2, 8'h42);
        tick();
        tick();
        total++; if (char_out !== 8'h00) begin bad++; $display("FAIL rst_char got=%h exp=00", char_out); end
        total++; if (char_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", char_out_valid); end
        total++; if (grant_out !== 3'b000) begin bad++; $display("FAIL rst_grant got=%b exp=000", grant_out); end
        total++; if (req_ready_out !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b exp=000", req_ready_out); end
        total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout_out); end
        rst_n_in = 1'b1;
        tick();
        total++; if (grant_out !== 3'b010) begin bad++; $display("FAIL rst_first_grant got=%b exp=010", grant_out); end
        total++; if (req_ready_out !== 3'b010) begin bad++; $display("FAIL rst_first_ready got=%b exp=010", req_ready_out); end
        tick();
        total++; if (char_out !== 8'h41 || char_out_valid !== 1'b1) begin bad++; $display("FAIL rst_first_char got=%h/%b exp=41/1", char_out, char_out_valid); end
        // Asynchronous reset in the middle of a line.
        rst_n_in = 1'b0;
        #1;
        total++; if (char_out !== 8'h00) begin bad++; $display("FAIL midrst_char got=%h exp=00", char_out); end
        total++; if (char_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", char_out_valid); end
        total++; if (grant_out !== 3'b000) begin bad++; $display("FAIL midrst_grant got=%b exp=000", grant_out); end
        total++; if (req_ready_out !== 3'b000) begin bad++; $display("FAIL midrst_ready got=%b exp=000", req_ready_out); end
        req_valid_in = '0;
        tick();
        rst_n_in = 1'b1;
    endtask

    task automatic test_single_line();
        do_reset();
        req_valid_in = 3'b001;
        set_char(0, 8'h6F);
        tick();
        total++; if (grant_out !== 3'b001) begin bad++; $display("FAIL single_grant got=%b exp=001", grant_out); end
        total++; if (req_ready_out !== 3'b001) begin bad++; $display("FAIL single_ready got=%b exp=001", req_ready_out); end
        total++; if (char_out_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid got=%b exp=0", char_out_valid); end
        tick();
        total++; if (char_out !== 8'h6F || char_out_valid !== 1'b1) begin bad++; $display("FAIL single_c0 got=%h/%b exp=6f/1", char_out, char_out_valid); end
        set_char(0, 8'h6B);
        tick();
        total++; if (char_out !== 8'h6B || char_out_valid !== 1'b1) begin bad++; $display("FAIL single_c1 got=%h/%b exp=6b/1", char_out, char_out_valid); end
        set_char(0, 8'h0A);
        tick();
        total++; if (char_out !== 8'h0A || char_out_valid !== 1'b1) begin bad++; $display("FAIL single_nl got=%h/%b exp=0a/1", char_out, char_out_valid); end
        total++; if (grant_out !== 3'b000) begin bad++; $display("FAIL single_release got=%b exp=000", grant_out); end
        req_valid_in = '0;
        tick();
        total++; if (char_out_valid !== 1'b0 || grant_out !== 3'b000) begin bad++; $display("FAIL single_idle got=%b/%b exp=0/000", char_out_valid, grant_out); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid_in = 3'b101;
        set_char(0, 8'h61);
        set_char(2, 8'h61);
        tick();
        total++; if (grant_out !== 3'b001) begin bad++; $display("FAIL rr_grant0 got=%b exp=001", grant_out); end
        total++; if (req_ready_out !== 3'b001) begin bad++; $display("FAIL rr_ready0 got=%b exp=001", req_ready_out); end
        tick();
        total++; if (char_out !== 8'h61) begin bad++; $display("FAIL rr_l0_a got=%h exp=61", char_out); end
        set_char(0, 8'h62);
        tick();
        total++; if (char_out !== 8'h62) begin bad++; $display("FAIL rr_l0_b got=%h exp=62", char_out); end
        set_char(0, 8'h0A);
        tick();
        total++; if (char_out !== 8'h0A || grant_out !== 3'b000) begin bad++; $display("FAIL rr_l0_nl got=%h/%b exp=0a/000", char_out, grant_out); end
        req_valid_in = 3'b100;
        total++; if (req_ready_out !== 3'b000) begin bad++; $display("FAIL rr_bubble_ready got=%b exp=000", req_ready_out); end
        tick();
        total++; if (grant_out !== 3'b100) begin bad++; $display("FAIL rr_grant2 got=%b exp=100", grant_out); end
        total++; if (char_out_valid !== 1'b0) begin bad++; $display("FAIL rr_bubble_valid got=%b exp=0", char_out_valid); end
        tick();
        total++; if (char_out !== 8'h61 || char_out_valid !== 1'b1) begin bad++; $display("FAIL rr_l1_a got=%h/%b exp=61/1", char_out, char_out_valid); end
        set_char(2, 8'h62);
        tick();
        total++; if (char_out !== 8'h62) begin bad++; $display("FAIL rr_l1_b got=%h exp=62", char_out); end
        set_char(2, 8'h0A);
        tick();
        total++; if (char_out !== 8'h0A || grant_out !== 3'b000) begin bad++; $display("FAIL rr_l1_nl got=%h/%b exp=0a/000", char_out, grant_out); end
        req_valid_in = 3'b011;
        set_char(0, 8'h0A);
        set_char(1, 8'h7A);
        tick();
        total++; if (grant_out !== 3'b001) begin bad++; $display("FAIL rr_grant0_again got=%b exp=001", grant_out); end
        total++; if (req_ready_out !== 3'b001) begin bad++; $display("FAIL rr_ignore_req1 got=%b exp=001", req_ready_out); end
        tick();
        total++; if (char_out !== 8'h0A) begin bad++; $display("FAIL rr_l2_nl got=%h exp=0a", char_out); end
        set_char(0, 8'h63);
        tick();
        total++; if (grant_out !== 3'b010) begin bad++; $display("FAIL rr_req1_wins got=%b exp=010", grant_out); end
        set_char(1, 8'h0A);
        tick();
        total++; if (char_out !== 8'h0A || grant_out !== 3'b000) begin bad++; $display("FAIL rr_l3_nl got=%h/%b exp=0a/000", char_out, grant_out); end
        req_valid_in = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid_in = 3'b001;
        set_char(0, 8'h70);
        tick();
        tick();
        total++; if (char_out !== 8'h70) begin bad++; $display("FAIL bp_first got=%h exp=70", char_out); end
        set_char(0, 8'h71);
        char_out_ready = 1'b0;
        #1;
        total++; if (req_ready_out !== 3'b000) begin bad++; $display("FAIL bp_ready_low got=%b exp=000", req_ready_out); end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (char_out !== 8'h70 || char_out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=%h/%b exp=70/1", k, char_out, char_out_valid); end
            total++; if (req_ready_out !== 3'b000) begin bad++; $display("FAIL bp_stall%0d got=%b exp=000", k, req_ready_out); end
        end
        char_out_ready = 1'b1;
        #1;
        total++; if (req_ready_out !== 3'b001) begin bad++; $display("FAIL bp_ready_back got=%b exp=001", req_ready_out); end
        tick();
        total++; if (char_out !== 8'h71) begin bad++; $display("FAIL bp_q got=%h exp=71", char_out); end
        set_char(0, 8'h72);
        tick();
        total++; if (char_out !== 8'h72) begin bad++; $display("FAIL bp_r got=%h exp=72", char_out); end
        set_char(0, 8'h0A);
        tick();
        total++; if (char_out !== 8'h0A || grant_out !== 3'b000) begin bad++; $display("FAIL bp_nl got=%h/%b exp=0a/000", char_out, grant_out); end
        total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL bp_no_timeout got=%b exp=0", timeout_out); end
        req_valid_in = '0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req_valid_in = 3'b010;
        set_char(1, 8'h78);
        tick();
        total++; if (grant_out !== 3'b010) begin bad++; $display("FAIL to_grant1 got=%b exp=010", grant_out); end
        tick();
        total++; if (char_out !== 8'h78) begin bad++; $display("FAIL to_x got=%h exp=78", char_out); end
        req_valid_in = 3'b100;
        set_char(2, 8'h79);
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++; if (timeout_out !== 1'b0 || grant_out !== 3'b010) begin bad++; $display("FAIL to_wait%0d got=%b/%b exp=0/010", k, timeout_out, grant_out); end
            total++; if (req_ready_out[2] !== 1'b0) begin bad++; $display("FAIL to_ignore2_%0d got=%b exp=0", k, req_ready_out[2]); end
        end
        tick();
        total++; if (timeout_out !== 1'b1 || grant_out !== 3'b000) begin bad++; $display("FAIL to_pulse got=%b/%b exp=1/000", timeout_out, grant_out); end
        tick();
        total++; if (char_out !== 8'h0A || char_out_valid !== 1'b1) begin bad++; $display("FAIL to_flush got=%h/%b exp=0a/1", char_out, char_out_valid); end
        total++; if (timeout_out !== 1'b0) begin bad++; $display("FAIL to_pulse_end got=%b exp=0", timeout_out); end
        tick();
        total++; if (grant_out !== 3'b100) begin bad++; $display("FAIL to_grant2 got=%b exp=100", grant_out); end
        set_char(2, 8'h0A);
        tick();
        total++; if (char_out !== 8'h0A || grant_out !== 3'b000) begin bad++; $display("FAIL to_req2_nl got=%h/%b exp=0a/000", char_out, grant_out); end
        req_valid_in = '0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_line();
        test_round_robin();
        test_backpressure();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
